spart_tx: RTL and testbench
===========================

# spart_tx

UART transmit stage of the SPART, directly downstream of the baud rate generator. It takes processor writes to the transmit buffer at ioaddr 2'b00 and consumes the generator's txenable pulses, which arrive at 16x the baud rate. It serialises each byte as a standard 8N1 frame on txd and reports buffer availability on tbr. A one-entry holding register in front of the shift register lets software queue the next byte while the current one is on the line.

## Interface
- TICKS_PER_BIT, 16, enable pulses per bit period (must be ≥2)
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- iocs  input  1  chip select for the SPART bus
- iorw  input  1  1 = read, 0 = write
- ioaddr  input  2  register select; 2'b00 = transmit buffer
- data  input  8  write data from the bus
- enable  input  1  single-cycle baud tick (txenable from the baud rate generator)
- txd  output  1  serial line, idle high
- tbr  output  1  transmit buffer ready: 1 = holding register empty

## Operation
- Write strobe: wr = iocs & ~iorw & (ioaddr == 2'b00).
- Holding register (THR, 8 bits, full flag). When wr & tbr, capture data and set full. When wr & ~tbr, drop the write; THR is unchanged and no error is flagged.
- tbr = ~full (registered flag, no combinational path from wr).
- Shift register (8 bits), tick counter (4 bits, counts 0..TICKS_PER_BIT-1), bit counter (3 bits).
- FSM states: IDLE, START, DATA, STOP.
- IDLE: txd=1, tick counter held at 0, enable ignored. If full, go to START on the next edge: copy THR into the shift register, clear full, and clear the tick counter.
- START: txd=0. Each enable increments the tick counter. On an enable with tick = TICKS_PER_BIT-1, go to DATA with tick=0 and bit=0.
- DATA: txd = shift[0], so bits go LSB first. On an enable with tick = TICKS_PER_BIT-1:
  - bit<7: shift right and increment bit.
  - bit==7: go to STOP.
- STOP: txd=1. On an enable with tick = TICKS_PER_BIT-1:
  - if full: load THR exactly as in IDLE and go straight to START, giving back-to-back frames with no idle gap.
  - otherwise: go to IDLE.
- Simultaneous wr and THR transfer in the same cycle: the write is rejected, because tbr is still 0 in that cycle. Software must poll tbr.
- Cycles without enable hold all counters.
- Reads and writes to other ioaddr values have no effect.

## Timing
- Reset values:
  - txd=1, tbr=1
  - state=IDLE, tick=0, bit=0, full=0, THR=0, shift=0
  - applies immediately on rst assertion, independent of clk.
- Reset mid-frame aborts the frame. txd goes high asynchronously and the pending THR byte is discarded.
- Write accepted at edge N:
  - tbr=0 after edge N.
  - edge N+1: START, txd=0, tbr=1.
- Start bit length: from the start edge until the edge sampling the TICKS_PER_BIT-th enable.
- Each data and stop bit spans exactly TICKS_PER_BIT enables.
- Frame = 10·TICKS_PER_BIT enables (160 by default).
- Back-to-back frames: the stop→start transition occurs on the edge of the final stop enable.
- Latency from wr to the txd falling edge: 2 clock edges when idle, independent of enable phase.

## Test plan
- Reset: assert rst mid-cycle → txd=1 and tbr=1 immediately; release and hold 100 cycles with enable toggling → txd stays 1.
- Single byte 0xA5, enable every 4 clk:
  - tbr falls the cycle after the write and rises 1 cycle later.
  - txd shows 0,1,0,1,0,0,1,0,1,1, each bit for 16 enables (64 clk).
  - then IDLE.
- Back-to-back: write 0x00, wait for tbr=1, write 0xFF:
  - second start bit begins on the edge ending the first stop bit.
  - no extra idle high.
  - total 320 enables.
- Overrun: write 0x11, then 0x22 (accepted into THR), then 0x33 while tbr=0 → 0x33 dropped; line carries 0x11 then 0x22 only.
- Write to ioaddr 2'b01/10/11, or with iorw=1 → tbr stays 1, txd stays 1.
- Reset at bit 4 of a frame with THR full → txd=1 and tbr=1 at once; after release no frame is sent until a new write.

Source files
------------

// File: rtl/spart_tx_if.sv
// SPART transmit-side bus bundle: processor register access, baud tick and
// serial line/status outputs.
interface spart_tx_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic [7:0] data;
   logic       enable;
   logic       txd;
   logic       tbr;

   modport master (output iocs, iorw, ioaddr, data, enable, input txd, tbr);
   modport slave  (input iocs, iorw, ioaddr, data, enable, output txd, tbr);
endinterface

// File: rtl/spart_tx.sv
// SPART UART transmitter: one-entry holding register feeding an 8N1 shift
// register, bit timing driven by the 16x baud enable.
module spart_tx #(
   parameter int TICKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   spart_tx_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // The tick counter is 4 bits wide, so TICKS_PER_BIT must lie in 2..16.
   localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);

   state_t     r_state, w_state_next;
   logic [3:0] r_tick,  w_tick_next;
   logic [2:0] r_bit,   w_bit_next;
   logic       r_full,  w_full_next;
   logic [7:0] r_thr,   w_thr_next;
   logic [7:0] r_shift, w_shift_next;

   logic w_wr;
   logic w_accept;
   logic w_load;
   logic w_bit_end;
   logic w_txd;

   assign w_wr      = bus.iocs & ~bus.iorw & (bus.ioaddr == 2'b00);
   // A write landing in the same cycle as a THR transfer still sees full=1
   // and is dropped; software must poll tbr.
   assign w_accept  = w_wr & ~r_full;
   assign w_bit_end = bus.enable & (r_tick == TICK_LAST);

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_tick_next  = r_tick;
      w_bit_next   = r_bit;
      w_shift_next = r_shift;
      w_load       = 1'b0;

      if (r_state != S_IDLE && bus.enable)
         w_tick_next = w_bit_end ? 4'd0 : r_tick + 4'd1;

      unique case (r_state)
         S_IDLE: begin
            w_tick_next = 4'd0;
            if (r_full) begin
               w_load       = 1'b1;
               w_state_next = S_START;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_bit_next   = 3'd0;
               w_state_next = S_DATA;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               if (r_bit == 3'd7) begin
                  w_state_next = S_STOP;
               end else begin
                  w_shift_next = {1'b0, r_shift[7:1]};
                  w_bit_next   = r_bit + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               if (r_full) begin
                  w_load       = 1'b1;
                  w_state_next = S_START;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      if (w_load)
         w_shift_next = r_thr;
   end

   assign w_thr_next  = w_accept ? bus.data : r_thr;
   assign w_full_next = w_accept ? 1'b1 : (w_load ? 1'b0 : r_full);

   always_comb begin
      w_txd = 1'b1;
      unique case (r_state)
         S_START: w_txd = 1'b0;
         S_DATA:  w_txd = r_shift[0];
         default: w_txd = 1'b1;
      endcase
   end

   // txd decodes straight from reset-cleared state, so a reset forces the
   // line high without waiting for a clock edge.
   assign bus.txd = w_txd;
   assign bus.tbr = ~r_full;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_tick  <= 4'd0;
         r_bit   <= 3'd0;
         r_full  <= 1'b0;
         r_thr   <= 8'h00;
         r_shift <= 8'h00;
      end else begin
         r_state <= w_state_next;
         r_tick  <= w_tick_next;
         r_bit   <= w_bit_next;
         r_full  <= w_full_next;
         r_thr   <= w_thr_next;
         r_shift <= w_shift_next;
      end
   end

endmodule

// File: tb/tb_spart_tx.sv
// Self-checking bench for spart_tx: scoreboard of accepted bytes, a line
// monitor that decodes 8N1 frames by counting baud enables.
module tb_spart_tx;

   localparam int TPB       = 16;
   localparam int FRAME_ENS = 10 * TPB;

   logic clk;
   logic rst;

   spart_tx_if bus_if ();

   spart_tx #(.TICKS_PER_BIT(TPB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] sb_q[$];

   int         frames_done   = 0;
   int         en_total      = 0;
   int         start_en      = 0;
   int         prev_start_en = 0;
   int         pair_len      = 0;
   int         gap           = 0;
   int         last_gap      = 0;
   bit         in_frame      = 0;
   int         cnt           = 0;
   logic [7:0] cur           = 8'h00;
   logic [7:0] rx            = 8'h00;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx >= 9) return 1'b1;
      return b[idx-1];
   endfunction

   // Baud tick: one enable every 4 clocks, free running.
   initial begin
      int ph = 0;
      bus_if.enable = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         ph = (ph == 3) ? 0 : ph + 1;
         bus_if.enable = (ph == 0);
      end
   end

   // Line monitor: enables seen high at a negedge are consumed by the next posedge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            in_frame = 0;
            cnt      = 0;
            gap      = 0;
         end else begin
            if (!in_frame && bus_if.txd == 1'b0) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_frame", 1, 0);
                  cur = 8'h00;
               end else begin
                  cur = sb_q.pop_front();
               end
               in_frame      = 1;
               cnt           = 0;
               last_gap      = gap;
               prev_start_en = start_en;
               start_en      = en_total;
            end
            if (in_frame) begin
               check("txd_bit", bus_if.txd, frame_bit(cur, cnt / TPB));
               if (bus_if.enable) begin
                  if ((cnt % TPB) == TPB / 2 && cnt / TPB >= 1 && cnt / TPB <= 8)
                     rx[cnt / TPB - 1] = bus_if.txd;
                  cnt++;
                  en_total++;
                  if (cnt == FRAME_ENS) begin
                     check("rx_byte", rx, cur);
                     in_frame = 0;
                     frames_done++;
                     pair_len = en_total - prev_start_en;
                     gap      = 0;
                  end
               end
            end else begin
               if (bus_if.enable) en_total++;
               gap++;
            end
         end
      end
   end

   task automatic bus_write(input logic [1:0] addr, input logic rw, input logic [7:0] d,
                            input bit exp_accept);
      @(posedge clk);
      #1;
      bus_if.iocs   = 1'b1;
      bus_if.iorw   = rw;
      bus_if.ioaddr = addr;
      bus_if.data   = d;
      if (exp_accept) sb_q.push_back(d);
      @(posedge clk);
      #1;
      bus_if.iocs   = 1'b0;
      bus_if.iorw   = 1'b1;
      bus_if.ioaddr = 2'b00;
      bus_if.data   = 8'h00;
   endtask

   task automatic wait_frames(input int target, input int budget, input string tag);
      int n = 0;
      while (frames_done < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      check(tag, frames_done, target);
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (i % 50 == 0) begin
            check({tag, "_txd"}, bus_if.txd, 1'b1);
            check({tag, "_tbr"}, bus_if.tbr, 1'b1);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int fd;
      int budget;

      rst           = 1'b0;
      bus_if.iocs   = 1'b0;
      bus_if.iorw   = 1'b1;
      bus_if.ioaddr = 2'b00;
      bus_if.data   = 8'h00;

      // Reset asserted mid-cycle, before any clock edge.
      #2 rst = 1'b1;
      #1;
      check("rst_txd", bus_if.txd, 1'b1);
      check("rst_tbr", bus_if.tbr, 1'b1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (i % 10 == 0) begin
            check("post_rst_txd", bus_if.txd, 1'b1);
            check("post_rst_tbr", bus_if.tbr, 1'b1);
         end
      end

      // Single byte: tbr low for one cycle, start bit on the following edge.
      fd = frames_done;
      bus_write(2'b00, 1'b0, 8'hA5, 1'b1);
      check("a5_tbr_fall", bus_if.tbr, 1'b0);
      check("a5_txd_pre", bus_if.txd, 1'b1);
      @(posedge clk);
      #1;
      check("a5_tbr_rise", bus_if.tbr, 1'b1);
      check("a5_txd_start", bus_if.txd, 1'b0);
      wait_frames(fd + 1, 1000, "a5_frame_done");
      idle_cycles(100, "a5_idle");
      check("a5_sb_empty", sb_q.size(), 0);

      // Back-to-back frames with no idle gap.
      fd = frames_done;
      bus_write(2'b00, 1'b0, 8'h00, 1'b1);
      @(posedge clk);
      #1;
      check("b2b_tbr_first", bus_if.tbr, 1'b1);
      bus_write(2'b00, 1'b0, 8'hFF, 1'b1);
      check("b2b_tbr_held", bus_if.tbr, 1'b0);
      wait_frames(fd + 2, 2000, "b2b_frames_done");
      check("b2b_gap", last_gap, 0);
      check("b2b_total_enables", pair_len, 2 * FRAME_ENS);
      idle_cycles(50, "b2b_idle");

      // Overrun: third byte arrives while THR is full and must be dropped.
      fd = frames_done;
      bus_write(2'b00, 1'b0, 8'h11, 1'b1);
      @(posedge clk);
      #1;
      bus_write(2'b00, 1'b0, 8'h22, 1'b1);
      check("ovr_tbr_full", bus_if.tbr, 1'b0);
      bus_write(2'b00, 1'b0, 8'h33, 1'b0);
      check("ovr_tbr_still_full", bus_if.tbr, 1'b0);
      wait_frames(fd + 2, 2000, "ovr_frames_done");
      idle_cycles(800, "ovr_idle");
      check("ovr_no_third", frames_done, fd + 2);
      check("ovr_sb_empty", sb_q.size(), 0);

      // Accesses that are not transmit-buffer writes.
      fd = frames_done;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] a;
         logic       rw;
         a  = (k < 3) ? 2'(k + 1) : 2'b00;
         rw = (k == 3);
         bus_write(a, rw, 8'h77, 1'b0);
         check("other_tbr", bus_if.tbr, 1'b1);
         check("other_txd", bus_if.txd, 1'b1);
      end
      idle_cycles(700, "other_idle");
      check("other_no_frame", frames_done, fd);

      // Reset during data bit 4 with THR full aborts everything.
      fd = frames_done;
      bus_write(2'b00, 1'b0, 8'hC3, 1'b1);
      @(posedge clk);
      #1;
      bus_write(2'b00, 1'b0, 8'h5A, 1'b1);
      check("mid_tbr_full", bus_if.tbr, 1'b0);
      budget = 0;
      while (!(in_frame && cnt >= 5 * TPB + 2) && budget < 1000) begin
         @(posedge clk);
         budget++;
      end
      check("mid_reached_bit4", (budget < 1000), 1'b1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_txd", bus_if.txd, 1'b1);
      check("mid_rst_tbr", bus_if.tbr, 1'b1);
      sb_q.delete();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      idle_cycles(800, "mid_after_rst");
      check("mid_no_frame", frames_done, fd);

      // Recovery: a fresh write is transmitted normally.
      bus_write(2'b00, 1'b0, 8'h3C, 1'b1);
      @(posedge clk);
      #1;
      check("rec_txd_start", bus_if.txd, 1'b0);
      wait_frames(fd + 1, 1000, "rec_frame_done");
      check("rec_sb_empty", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
